// File: rtl/adder_result_stage.sv
// adder_result_stage
// Two-entry result FIFO behind a 6-bit ripple adder. Each accepted sum is
// stored together with its signed-overflow flag; the head entry is
// presented with zero/negative/overflow flags derived from the stored data.
// A saturating counter tracks how many overflowed results were accepted.
//
// Optional feature (macro ADDER_RESULT_SAT_EN): when defined, overflowed
// sums are clamped to the most positive / most negative 6-bit value
// instead of being stored wrapped.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream result valid
//   in_ready   stage can accept an entry this cycle
//   in_sum     6-bit sum from the adder
//   in_x_msb   bit 5 of operand x
//   in_y_msb   bit 5 of operand y
//   out_valid  head entry available
//   out_ready  downstream accepts the head entry
//   out_data   head entry result (0 when empty)
//   out_zero   head entry equals zero
//   out_neg    head entry is negative
//   out_ovf    head entry overflowed
//   ovf_count  overflowed entries accepted since reset, saturates at 15
//   level      current occupancy 0..2
//
// state | meaning
// EMPTY | no entries stored
// ONE   | one entry stored, head valid
// FULL  | two entries stored, no push accepted
module adder_result_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_sum,
    input  logic       in_x_msb,
    input  logic       in_y_msb,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic       out_zero,
    output logic       out_neg,
    output logic       out_ovf,
    output logic [3:0] ovf_count,
    output logic [1:0] level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [5:0] data_mem [2];
    logic       ovf_mem  [2];
    logic       wr_ptr;
    logic       rd_ptr;

    logic       push;
    logic       pop;
    logic       push_ovf;
    logic [5:0] push_data;
    logic [5:0] head_data;

    // Same-sign operands producing a result of the other sign.
    assign push_ovf = (in_x_msb == in_y_msb) && (in_sum[5] != in_x_msb);

`ifdef ADDER_RESULT_SAT_EN
    always_comb begin
        push_data = in_sum;
        if (push_ovf) begin
            push_data = in_x_msb ? 6'b100000 : 6'b011111;
        end
    end
`else
    assign push_data = in_sum;
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        level      = 2'd0;
        case (state)
            EMPTY: begin
                if (push) state_next = ONE;
            end
            ONE: begin
                out_valid = 1'b1;
                level     = 2'd1;
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                level     = 2'd2;
                if (pop) state_next = ONE;
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            ovf_count   <= 4'd0;
            data_mem[0] <= 6'd0;
            data_mem[1] <= 6'd0;
            ovf_mem[0]  <= 1'b0;
            ovf_mem[1]  <= 1'b0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                ovf_mem[wr_ptr]  <= push_ovf;
                wr_ptr           <= ~wr_ptr;
                if (push_ovf && (ovf_count != 4'd15)) begin
                    ovf_count <= ovf_count + 4'd1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Head is forced to zero while empty so stale entries never show.
    assign head_data = out_valid ? data_mem[rd_ptr] : 6'd0;
    assign out_data  = head_data;
    assign out_zero  = out_valid && (head_data == 6'd0);
    assign out_neg   = out_valid && head_data[5];
    assign out_ovf   = out_valid && ovf_mem[rd_ptr];

endmodule

// File: tb/tb_adder_result_stage.sv
module tb_adder_result_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_sum = 6'd0;
    logic       in_x_msb = 1'b0;
    logic       in_y_msb = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_data;
    logic       out_zero;
    logic       out_neg;
    logic       out_ovf;
    logic [3:0] ovf_count;
    logic [1:0] level;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of stored entries {ovf, data} plus counter.
    logic [6:0] q[$];
    int         m_ovf_cnt = 0;

    adder_result_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_x_msb  (in_x_msb),
        .in_y_msb  (in_y_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] stored_value(input logic [5:0] s, input logic xm, input logic ov);
`ifdef ADDER_RESULT_SAT_EN
        if (ov) return xm ? 6'b100000 : 6'b011111;
`endif
        return s;
    endfunction

    task automatic check_all();
        logic [5:0] hd;
        logic       hv;
        logic       ho;
        hv = (q.size() > 0);
        hd = hv ? q[0][5:0] : 6'd0;
        ho = hv ? q[0][6] : 1'b0;
        chk("level",     {6'd0, level},        8'(q.size()));
        chk("in_ready",  {7'd0, in_ready},     {7'd0, q.size() < 2});
        chk("out_valid", {7'd0, out_valid},    {7'd0, hv});
        chk("out_data",  {2'd0, out_data},     {2'd0, hd});
        chk("out_zero",  {7'd0, out_zero},     {7'd0, hv && (hd == 6'd0)});
        chk("out_neg",   {7'd0, out_neg},      {7'd0, $signed(hd) < 0});
        chk("out_ovf",   {7'd0, out_ovf},      {7'd0, ho});
        chk("ovf_count", {4'd0, ovf_count},    8'(m_ovf_cnt));
    endtask

    // One clock: drive inputs, check state-only outputs mid-cycle, then
    // advance the model by the handshakes the spec defines.
    task automatic cyc(input logic v, input logic [5:0] s, input logic xm, input logic ym,
                       input logic ordy, input logic r);
        logic       do_push;
        logic       do_pop;
        logic       ov;
        logic [6:0] head;
        rst = r; in_valid = v; in_sum = s; in_x_msb = xm; in_y_msb = ym; out_ready = ordy;
        @(negedge clk);
        check_all();
        do_push = v && (q.size() < 2);
        do_pop  = ordy && (q.size() > 0);
        ov = (xm == ym) && (s[5] != xm);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf_cnt = 0;
        end else begin
            if (do_pop) head = q.pop_front();
            if (do_push) begin
                q.push_back({ov, stored_value(s, xm, ov)});
                if (ov && m_ovf_cnt < 15) m_ovf_cnt++;
            end
        end
        #1;
    endtask

    initial begin
        logic [5:0] x;
        logic [5:0] y;
        logic [5:0] s;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, then first push right after reset (5, no ovf).
        cyc(1, 6'd5, 0, 0, 0, 0);
        cyc(0, 6'd0, 0, 0, 0, 0);
        chk("d5_data", {2'd0, out_data}, 8'd5);

        // Fill with 3,4; 7 refused; drain in order.
        cyc(0, 6'd0, 0, 0, 0, 1);
        cyc(1, 6'd3, 0, 0, 0, 0);
        cyc(1, 6'd4, 0, 0, 0, 0);
        cyc(1, 6'd7, 0, 0, 0, 0);
        chk("full_ready", {7'd0, in_ready}, 8'd0);
        cyc(0, 6'd0, 0, 0, 1, 0);
        cyc(0, 6'd0, 0, 0, 1, 0);
        cyc(0, 6'd0, 0, 0, 0, 0);

        // Positive overflow.
        cyc(1, 6'b100000, 0, 0, 0, 0);
        cyc(0, 6'd0, 0, 0, 0, 0);
        cyc(0, 6'd0, 0, 0, 1, 0);
        // Negative overflow.
        cyc(1, 6'b011111, 1, 1, 0, 0);
        cyc(0, 6'd0, 0, 0, 1, 0);

        // Simultaneous push/pop at level 1.
        cyc(1, 6'd12, 0, 0, 0, 0);
        cyc(1, 6'd9, 0, 0, 1, 0);
        cyc(0, 6'd0, 0, 0, 0, 0);
        chk("pp_data", {2'd0, out_data}, 8'd9);
        cyc(0, 6'd0, 0, 0, 1, 0);
        // Zero entry.
        cyc(1, 6'd0, 1, 0, 0, 0);
        cyc(0, 6'd0, 0, 0, 1, 0);

        // 16 overflowed pushes with continuous drain: counter saturates.
        for (int i = 0; i < 16; i++) cyc(1, 6'b100001 + 6'(i % 8), 0, 0, 1, 0);
        cyc(1, 6'd1, 0, 0, 0, 0);
        cyc(0, 6'd0, 0, 0, 0, 0);
        chk("sat15", {4'd0, ovf_count}, 8'd15);
        // Reset with level 2, push/pop ignored that cycle.
        cyc(1, 6'd2, 0, 0, 1, 1);
        cyc(0, 6'd0, 0, 0, 0, 0);

        // Random traffic from operand pairs, occasional reset.
        for (int i = 0; i < 400; i++) begin
            x = 6'($urandom);
            y = 6'($urandom);
            s = x + y;
            cyc(1'($urandom_range(0, 3) != 0), s, x[5], y[5],
                1'($urandom_range(0, 2) != 0), $urandom_range(0, 59) == 0);
        end
        cyc(0, 6'd0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 Parameter: none; FIFO depth is fixed at 2 entries, data width fixed at 6 bits (2's complement).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream adder result valid.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 in_sum  input  6  sum z from the 6-bit ripple adder.
REQ-007 in_x_msb  input  1  bit 5 of adder operand x.
REQ-008 in_y_msb  input  1  bit 5 of adder operand y.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_data  output  6  head entry result.
REQ-012 out_zero / out_neg / out_ovf  output  1 each  head entry flags.
REQ-013 ovf_count  output  4  number of overflowed entries accepted since reset.
REQ-014 level  output  2  current occupancy (0..2).

Function
REQ-015 Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff out_valid && out_ready.
REQ-016 State machine SHALL have states EMPTY (level 0), ONE (level 1), FULL (level 2).
REQ-017 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; all other cases hold.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL (no push in FULL even with simultaneous pop).
REQ-019 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; no combinational bypass: latency push->out_valid is exactly 1 cycle.
REQ-020 Overflow SHALL be computed at push: ovf = (in_x_msb == in_y_msb) && (in_sum[5] != in_x_msb).
REQ-021 Stored data SHALL be in_sum unless saturation applies (REQ-031).
REQ-022 Flags SHALL be computed from stored data: zero = (data == 0), neg = data[5]; ovf stored with entry.
REQ-023 Entries SHALL leave in push order; read/write pointers wrap 1->0.
REQ-024 ONE+push+pop: head entry leaves, new entry becomes head next cycle; no entry lost or duplicated.
REQ-025 In EMPTY, out_data and flags SHALL be 0.
REQ-026 ovf_count SHALL increment by 1 on each push with ovf=1 and saturate at 15 (no wrap).
REQ-027 Outputs SHALL not change except on push, pop or reset.

Reset
REQ-028 rst SHALL force state EMPTY, pointers 0, level 0, ovf_count 0, out_valid 0, in_ready 1, out_data 0, all flags 0 on the next rising edge.
REQ-029 rst asserted mid-operation SHALL discard all stored entries; push/pop in that cycle SHALL be ignored.
REQ-030 First push SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-031 Macro ADDER_RESULT_SAT_EN: when defined, an overflowed entry SHALL be stored as 6'b011111 if in_x_msb=0, 6'b100000 if in_x_msb=1, with out_ovf still 1; when undefined, wrapped in_sum SHALL be stored unchanged.

Verification
REQ-032 Reset, push in_sum=6'd5 (x_msb=0,y_msb=0), out_ready=0 -> next cycle out_valid=1, out_data=5, flags 0, level=1.
REQ-033 Push 3, 4, then 7 with out_ready=0 -> in_ready=0 after second push, third not accepted, pops return 3 then 4, level 0.
REQ-034 Push in_sum=6'b100000, x_msb=0, y_msb=0 -> out_ovf=1, ovf_count=1; out_data=6'b011111 with ADDER_RESULT_SAT_EN, 6'b100000 without.
REQ-035 level=1, simultaneous push 9 and pop -> level stays 1, popped value is old head, out_data=9 next cycle.
REQ-036 16 overflowed pushes (draining continuously) -> ovf_count=15; assert rst with level=2 -> next cycle level=0, ovf_count=0, out_valid=0, in_ready=1.
